// File: rtl/burst_mem_pkg.sv
// Shared constants, state encoding and burst-length decode for the burst memory responder.
package burst_mem_pkg;

  localparam logic [1:0] SZ_1  = 2'b00;
  localparam logic [1:0] SZ_4  = 2'b01;
  localparam logic [1:0] SZ_8  = 2'b10;
  localparam logic [1:0] SZ_16 = 2'b11;

  localparam logic [31:0] DEF_START_ADDR = 32'h8002_0000;
  localparam int          DEF_DEPTH      = 1024;

  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

  function automatic logic [4:0] beat_count(input logic [1:0] size);
    case (size)
      SZ_1:    beat_count = 5'd1;
      SZ_4:    beat_count = 5'd4;
      SZ_8:    beat_count = 5'd8;
      default: beat_count = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one registered read port.
// Only the read register is reset; the array contents survive reset.
module burst_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/burst_mem_resp.sv
// Burst memory responder: 1/4/8/16-word read/write bursts, one beat per clock.
// Optional range check enabled by `define BURST_MEM_RANGE_CHECK_EN (otherwise addressing wraps).
module burst_mem_resp
  import burst_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = DEF_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(DEF_START_ADDR)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            access_size,
  input  logic                  rw,
  input  logic                  enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt, base_idx, beat_idx;
  logic [3:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [4:0]            n_beats;
  logic                  reject, we, re;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  assign word_off = (address - START_ADDR) >> 2;
  assign base_idx = IDX_W'(word_off % ADDR_WIDTH'(DEPTH));
  assign n_beats  = beat_count(access_size);
  assign busy     = (state != IDLE);

`ifdef BURST_MEM_RANGE_CHECK_EN
  // base + N - 1 > DEPTH - 1, computed on the unwrapped word offset
  assign reject = (address < START_ADDR) ||
                  (word_off + ADDR_WIDTH'(n_beats) > ADDR_WIDTH'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= (state == IDLE) && enable && reject;
  end
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    beat_idx  = idx;
    we        = 1'b0;
    re        = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && !reject) begin
          beat_idx = base_idx;
          we       = !rw;
          re       = rw;
          idx_nxt  = next_idx(base_idx);
          cnt_nxt  = 4'(n_beats - 5'd1);
          if (n_beats != 5'd1) state_nxt = rw ? RBURST : WBURST;
        end
      end
      WBURST, RBURST: begin
        we      = (state == WBURST);
        re      = (state == RBURST);
        idx_nxt = next_idx(idx);
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // write gated by reset so an edge during reset cannot land a stray beat
  burst_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (we && !reset),
    .waddr (beat_idx),
    .wdata (data_in),
    .re    (re),
    .raddr (beat_idx),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_burst_mem_resp.sv
module tb_burst_mem_resp;

  localparam int          DEPTH = 64;
  localparam logic [31:0] START = 32'h8002_0000;
  localparam int          K_DOUT = 0, K_BUSY = 1, K_ERR = 2;

  logic        clock, reset, rw, enable, busy, err;
  logic [31:0] address, data_in, data_out;
  logic [1:0]  access_size;

  burst_mem_resp #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .access_size (access_size),
    .rw          (rw),
    .enable      (enable),
    .busy        (busy),
    .data_out    (data_out),
    .err         (err)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_rd = 32'h0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  function automatic string kname(input int k);
    case (k)
      K_BUSY:  return "busy";
      K_ERR:   return "err";
      default: return "data_out";
    endcase
  endfunction

  always @(negedge clock) begin : mon
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_BUSY:  act = {31'b0, busy};
          K_ERR:   act = {31'b0, err};
          default: act = data_out;
        endcase
        compared++;
        if (act !== sb[i].val) begin
          mismatched++;
          $display("FAIL %s test%0d cyc%0d: got %h expected %h",
                   kname(sb[i].kind), sb[i].tag, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  function automatic int nbeats(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] w;
    w = (a - START) >> 2;
    return int'(w % DEPTH);
  endfunction

  task automatic exp_all(input int c, input logic b, input logic [31:0] d,
                         input logic e, input int tag);
    sb.push_back('{c, K_BUSY, {31'b0, b}, tag});
    sb.push_back('{c, K_DOUT, d, tag});
    sb.push_back('{c, K_ERR, {31'b0, e}, tag});
  endtask

  task automatic burst(input logic rwv, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] d0, input int tag);
    int n = nbeats(sz);
    int base = widx(a);
    for (int i = 0; i < n; i++) begin
      enable      = (i == 0);
      rw          = (i == 0) ? rwv : ~rwv;
      address     = (i == 0) ? a : 32'h0;
      access_size = (i == 0) ? sz : ~sz;
      data_in     = d0 + i;
      if (rwv) last_rd = mdl[(base + i) % DEPTH];
      else     mdl[(base + i) % DEPTH] = d0 + i;
      exp_all(cyc + 1, i < n - 1, last_rd, 1'b0, tag);
      @(negedge clock);
    end
    enable = 1'b0;
  endtask

`ifdef BURST_MEM_RANGE_CHECK_EN
  task automatic reject_req(input logic rwv, input logic [31:0] a,
                            input logic [1:0] sz, input int tag);
    enable = 1'b1; rw = rwv; address = a; access_size = sz; data_in = 32'hBAD0_BAD0;
    exp_all(cyc + 1, 1'b0, last_rd, 1'b1, tag);
    @(negedge clock);
    enable = 1'b0;
    exp_all(cyc + 1, 1'b0, last_rd, 1'b0, tag);
    @(negedge clock);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa, pa, pb;
    reset = 1'b1; enable = 1'b0; rw = 1'b0; address = 32'h0;
    data_in = 32'h0; access_size = 2'b00;

    exp_all(1, 1'b0, 32'h0, 1'b0, 0);
    exp_all(2, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b0;

    burst(1'b0, 32'h8002_0000, 2'b00, 32'hDEAD_BEEF, 1);
    burst(1'b1, 32'h8002_0000, 2'b00, 32'h0, 1);
    compared++;
    if (data_out !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL data_out test1 direct: got %h expected deadbeef", data_out);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy test1 direct: got %b expected 0", busy);
    end

    burst(1'b0, 32'h8002_0040, 2'b11, 32'h0, 2);
    burst(1'b1, 32'h8002_0040, 2'b11, 32'h0, 2);
    compared++;
    if (data_out !== 32'd15) begin
      mismatched++;
      $display("FAIL data_out test2 direct: got %h expected 0000000f", data_out);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy test2 direct: got %b expected 0", busy);
    end

    pa = 32'h8002_0040;
    pb = 32'h8002_0044;
    enable = 1'b1; rw = 1'b1; access_size = 2'b01;
    for (int i = 0; i < 8; i++) begin
      address = (i == 0) ? pa : pb;
      last_rd = (i < 4) ? mdl[widx(pa) + i] : mdl[widx(pb) + i - 4];
      exp_all(cyc + 1, (i % 4) != 3, last_rd, 1'b0, 3);
      @(negedge clock);
    end
    enable = 1'b0;
    exp_all(cyc + 1, 1'b0, last_rd, 1'b0, 3);
    @(negedge clock);

`ifdef BURST_MEM_RANGE_CHECK_EN
    burst(1'b0, START + (DEPTH - 8) * 4, 2'b10, 32'h700, 4);
    reject_req(1'b0, 32'h8001_FFFC, 2'b00, 4);
    reject_req(1'b1, START + (DEPTH - 8) * 4, 2'b11, 4);
    reject_req(1'b0, START + (DEPTH - 8) * 4, 2'b11, 4);
    burst(1'b1, START + (DEPTH - 8) * 4, 2'b10, 32'h0, 4);
`else
    burst(1'b0, START + (DEPTH - 2) * 4, 2'b01, 32'h5000, 5);
    burst(1'b1, START + (DEPTH - 2) * 4, 2'b01, 32'h0, 5);
    burst(1'b1, START, 2'b00, 32'h0, 5);
    burst(1'b1, START + 4, 2'b00, 32'h0, 5);
`endif

    wa = START + 40 * 4;
    burst(1'b0, wa, 2'b10, 32'h11, 6);
    burst(1'b1, wa, 2'b00, 32'h0, 6);
    for (int i = 0; i < 5; i++) begin
      enable = (i == 0); rw = 1'b0; address = wa; access_size = 2'b10;
      data_in = 32'hA0 + i;
      mdl[widx(wa) + i] = 32'hA0 + i;
      exp_all(cyc + 1, 1'b1, last_rd, 1'b0, 6);
      @(negedge clock);
    end
    enable = 1'b0;
    data_in = 32'hA5;
    mdl[widx(wa) + 5] = 32'hA5;
    @(posedge clock);
    #2 reset = 1'b1;
    last_rd = 32'h0;
    exp_all(cyc, 1'b0, 32'h0, 1'b0, 6);
    #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy test6 direct: got %b expected 0 during reset", busy);
    end
    compared++;
    if (data_out !== 32'h0) begin
      mismatched++;
      $display("FAIL data_out test6 direct: got %h expected 0 during reset", data_out);
    end
    @(negedge clock);
    data_in = 32'hA6;
    exp_all(cyc + 1, 1'b0, 32'h0, 1'b0, 6);
    @(negedge clock);
    reset = 1'b0;
    exp_all(cyc + 1, 1'b0, 32'h0, 1'b0, 6);
    @(negedge clock);
    burst(1'b1, wa, 2'b10, 32'h0, 6);

    repeat (3) @(negedge clock);
    #1;
    foreach (sb[i]) begin
      compared++;
      mismatched++;
      $display("FAIL %s test%0d: expectation for cyc%0d never checked",
               kname(sb[i].kind), sb[i].tag, sb[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/burst_mem_resp.md
BURST_MEM_RESP -- requirements
Module: burst_mem_resp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter DEPTH, default 1024, storage size in words.
REQ-004 Parameter START_ADDR, default 32'h80020000, byte address of word 0.
REQ-005 clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 address  input  ADDR_WIDTH  byte address of the first beat; bits [1:0] ignored.
REQ-008 data_in  input  DATA_WIDTH  write data, one word per beat.
REQ-009 access_size  input  2  burst length: 00 = 1, 01 = 4, 10 = 8, 11 = 16 words.
REQ-010 rw  input  1  0 = write, 1 = read.
REQ-011 enable  input  1  transaction request; sampled only while idle.
REQ-012 busy  output  1  high while a burst is in progress after its first beat.
REQ-013 data_out  output  DATA_WIDTH  registered read data.
REQ-014 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-015 The FSM SHALL have states IDLE, WBURST and RBURST; busy SHALL be 1 exactly when the state is not IDLE.
REQ-016 Word index SHALL be ((address - START_ADDR) >> 2) modulo DEPTH.
REQ-017 In IDLE, a rising edge with enable=1 SHALL start a transaction: latch the base index, load beats-remaining = N-1, and perform beat 0 on that same edge.
REQ-018 Write beat: mem[index] <= data_in, then index advances by 1.
REQ-019 Read beat: data_out <= mem[index], valid after the edge, then index advances by 1.
REQ-020 If N=1, the state SHALL stay IDLE and busy SHALL stay 0.
REQ-021 If N>1, the next state SHALL be WBURST (rw=0) or RBURST (rw=1), and one beat SHALL be performed per subsequent edge.
REQ-022 rw and access_size SHALL be ignored after the start edge.
REQ-023 The edge that performs the last beat SHALL return the FSM to IDLE, so busy is high for exactly N-1 cycles.
REQ-024 enable SHALL be ignored while busy=1.
REQ-025 A request SHALL be accepted on the first edge where busy=0, including the edge immediately after a burst's last beat.
REQ-026 When the index passes DEPTH-1 it SHALL wrap to 0 (wrap applies only when REQ-031 is compiled out).
REQ-027 data_out SHALL hold its last value when no read beat occurs.
REQ-028 A write SHALL never alter data_out.

Reset
REQ-029 While reset=1, independent of clock: state = IDLE, busy = 0, data_out = 0, err = 0, beat counter = 0.
REQ-030 Storage contents SHALL NOT be cleared by reset. A reset mid-burst SHALL abandon the remaining beats; beats already written SHALL persist.

Configuration
REQ-031 Macro BURST_MEM_RANGE_CHECK_EN, when defined, enables the range check:
- A request is rejected if address < START_ADDR, or if base index + N - 1 > DEPTH-1.
- On rejection: no storage access, data_out unchanged, FSM stays IDLE, and err = 1 for one cycle.
REQ-032 Without BURST_MEM_RANGE_CHECK_EN, err SHALL be tied to 0 and addressing SHALL wrap per REQ-016 and REQ-026.

Structure
REQ-033 Package burst_mem_pkg SHALL hold:
- the access_size encoding constants;
- the state enumeration;
- the beat-count function mapping access_size to N;
- default START_ADDR and DEPTH constants.
REQ-034 Storage SHALL be a sub-module burst_mem_array with one synchronous write port and one synchronous read port of DEPTH x DATA_WIDTH. burst_mem_resp holds the FSM, counter and address logic.

Verification
REQ-035 Single write then read: write 32'hDEADBEEF to 32'h80020000 with access_size=00, then read it back -> data_out = 32'hDEADBEEF one edge after the read request; busy never asserts.
REQ-036 Burst write then read: 16-word write of 0..15 at 32'h80020040 with access_size=11, then a 16-word read -> busy high for 15 cycles in each burst; data_out sequence 0..15, one word per edge.
REQ-037 Back-to-back bursts: a 4-word read with enable held high throughout -> the second burst starts on the edge right after the last beat; no beat lost or duplicated; enable during busy is ignored.
REQ-038 Reset mid-burst: assert reset after beat 5 of an 8-word write of 32'hA0..A7 -> busy = 0 and data_out = 0 immediately; a later read shows words 0..5 = A0..A5 and words 6..7 unchanged.
REQ-039 Range check (macro on): request at 32'h8001FFFC, or a 16-word burst at index DEPTH-8 -> err pulses one cycle, busy stays 0, storage unchanged.
REQ-040 Wrap (macro off): a 4-word write at index DEPTH-2 -> words DEPTH-2, DEPTH-1, 0, 1 are written, and err stays 0.
